// File: rtl/exe_stage_nlane.sv
// exe_stage_nlane: N-lane execute stage with operand forwarding, ALU/immediate select,
// destination select and a multi-cycle multiply that holds the whole bundle.
module exe_stage_nlane #(
    parameter int unsigned LANES   = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 4,
    localparam int unsigned FSEL   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       valid_e,
    input  logic [8*LANES-1:0]     ctrl_e,
    input  logic [5*LANES-1:0]     rs_e,
    input  logic [5*LANES-1:0]     rt_e,
    input  logic [5*LANES-1:0]     rd_e,
    input  logic [WIDTH*LANES-1:0] rfout1_e,
    input  logic [WIDTH*LANES-1:0] rfout2_e,
    input  logic [WIDTH*LANES-1:0] imm_e,
    input  logic [WIDTH*LANES-1:0] upperimm_e,
    input  logic [FSEL*LANES-1:0]  forwarda_e,
    input  logic [FSEL*LANES-1:0]  forwardb_e,
    input  logic [WIDTH*LANES-1:0] execout_m,
    input  logic [WIDTH*LANES-1:0] result_w,
    input  logic                   stall_in,
    output logic                   busy_e,
    output logic [LANES-1:0]       valid_m,
    output logic [LANES-1:0]       regwrite_m,
    output logic [WIDTH*LANES-1:0] execout_q,
    output logic [5*LANES-1:0]     writereg_q
);
    localparam logic [3:0] OpMul    = 4'b0100;
    localparam bit         MulMulti = (MUL_LAT > 1);
    localparam logic [3:0] CntLast  = 4'(MUL_LAT - 1);

    typedef enum logic [0:0] {StIdle, StMulb} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [LANES-1:0]       lvalid_q, lvalid_d;
    logic [8*LANES-1:0]     lctrl_q, lctrl_d;
    logic [WIDTH*LANES-1:0] lsrca_q, lsrca_d;
    logic [WIDTH*LANES-1:0] lsrcb_q, lsrcb_d;
    logic [5*LANES-1:0]     lwreg_q, lwreg_d;
    logic [LANES-1:0]       valid_m_q, valid_m_d;
    logic [LANES-1:0]       regwrite_m_q, regwrite_m_d;
    logic [WIDTH*LANES-1:0] execout_d;
    logic [5*LANES-1:0]     writereg_d;

    logic [WIDTH*LANES-1:0] live_a, live_b, live_res, lat_res;
    logic [5*LANES-1:0]     live_wreg;
    logic [LANES-1:0]       live_rw, lat_rw;
    logic                   mul_present;

    // Source register specifiers are consumed by the hazard unit, not here.
    logic unused_rs;
    assign unused_rs = ^rs_e;

    function automatic logic [WIDTH-1:0] fwd_sel(input logic [FSEL-1:0] sel,
                                                 input logic [WIDTH-1:0] rf,
                                                 input logic [WIDTH*LANES-1:0] m,
                                                 input logic [WIDTH*LANES-1:0] w);
        logic [WIDTH-1:0] r;
        r = rf;
        for (int j = 0; j < int'(LANES); j++) begin
            if (int'(sel) == j + 1) r = m[j*WIDTH +: WIDTH];
            if (int'(sel) == j + 1 + int'(LANES)) r = w[j*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [3:0] op);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b1100: r = ~(a | b);
            4'b1000: r = a ^ b;
            4'b0111: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0101: r = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1001: r = a << b[4:0];
            4'b1010: r = a >> b[4:0];
            4'b1011: r = $signed(a) >>> b[4:0];
            4'b0100: r = a * b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Per-lane datapath for the live bundle and for the latched multiply bundle.
    // An upper-immediate lane carries upperimm in srcA so the latched copy needs no extra field.
    always_comb begin
        live_a      = '0;
        live_b      = '0;
        live_res    = '0;
        lat_res     = '0;
        live_wreg   = '0;
        live_rw     = '0;
        lat_rw      = '0;
        mul_present = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            live_a[k*WIDTH +: WIDTH] = ctrl_e[8*k+4] ? upperimm_e[k*WIDTH +: WIDTH] :
                fwd_sel(forwarda_e[k*FSEL +: FSEL], rfout1_e[k*WIDTH +: WIDTH], execout_m, result_w);
            live_b[k*WIDTH +: WIDTH] = ctrl_e[8*k+5] ? imm_e[k*WIDTH +: WIDTH] :
                fwd_sel(forwardb_e[k*FSEL +: FSEL], rfout2_e[k*WIDTH +: WIDTH], execout_m, result_w);
            live_res[k*WIDTH +: WIDTH] = ctrl_e[8*k+4] ? live_a[k*WIDTH +: WIDTH] :
                alu(live_a[k*WIDTH +: WIDTH], live_b[k*WIDTH +: WIDTH], ctrl_e[8*k +: 4]);
            live_wreg[5*k +: 5] = ctrl_e[8*k+6] ? rd_e[5*k +: 5] : rt_e[5*k +: 5];
            live_rw[k] = ctrl_e[8*k+7];
            if (valid_e[k] && (ctrl_e[8*k +: 4] == OpMul)) mul_present = 1'b1;
            lat_res[k*WIDTH +: WIDTH] = lctrl_q[8*k+4] ? lsrca_q[k*WIDTH +: WIDTH] :
                alu(lsrca_q[k*WIDTH +: WIDTH], lsrcb_q[k*WIDTH +: WIDTH], lctrl_q[8*k +: 4]);
            lat_rw[k] = lctrl_q[8*k+7];
        end
    end

    // Issue/multiply FSM and output-register next state; a downstream stall freezes everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lvalid_d     = lvalid_q;
        lctrl_d      = lctrl_q;
        lsrca_d      = lsrca_q;
        lsrcb_d      = lsrcb_q;
        lwreg_d      = lwreg_q;
        valid_m_d    = valid_m_q;
        regwrite_m_d = regwrite_m_q;
        execout_d    = execout_q;
        writereg_d   = writereg_q;
        if (!stall_in) begin
            unique case (state_q)
                StIdle: begin
                    if (mul_present && MulMulti) begin
                        state_d      = StMulb;
                        cnt_d        = 4'd1;
                        lvalid_d     = valid_e;
                        lctrl_d      = ctrl_e;
                        lsrca_d      = live_a;
                        lsrcb_d      = live_b;
                        lwreg_d      = live_wreg;
                        valid_m_d    = '0;
                        regwrite_m_d = '0;
                    end else begin
                        valid_m_d    = valid_e;
                        regwrite_m_d = valid_e & live_rw;
                        execout_d    = live_res;
                        writereg_d   = live_wreg;
                    end
                end
                StMulb: begin
                    if (cnt_q == CntLast) begin
                        state_d      = StIdle;
                        cnt_d        = 4'd0;
                        valid_m_d    = lvalid_q;
                        regwrite_m_d = lvalid_q & lat_rw;
                        execout_d    = lat_res;
                        writereg_d   = lwreg_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            lvalid_q     <= '0;
            lctrl_q      <= '0;
            lsrca_q      <= '0;
            lsrcb_q      <= '0;
            lwreg_q      <= '0;
            valid_m_q    <= '0;
            regwrite_m_q <= '0;
            execout_q    <= '0;
            writereg_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lvalid_q     <= lvalid_d;
            lctrl_q      <= lctrl_d;
            lsrca_q      <= lsrca_d;
            lsrcb_q      <= lsrcb_d;
            lwreg_q      <= lwreg_d;
            valid_m_q    <= valid_m_d;
            regwrite_m_q <= regwrite_m_d;
            execout_q    <= execout_d;
            writereg_q   <= writereg_d;
        end
    end

    assign valid_m    = valid_m_q;
    assign regwrite_m = regwrite_m_q;

    // While reset is held the stage is idle by construction, so only stall_in shows.
    assign busy_e = stall_in | (~reset &
                    (((state_q == StIdle) && mul_present && MulMulti) ||
                     ((state_q == StMulb) && (cnt_q != CntLast))));

endmodule

// File: tb/tb_exe_stage_nlane.sv
// Directed bench for exe_stage_nlane (LANES=2, WIDTH=32, MUL_LAT=4) with a result scoreboard.
module tb_exe_stage_nlane;
    localparam int unsigned LANES = 2;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned FSEL  = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [LANES-1:0]       valid_e;
    logic [8*LANES-1:0]     ctrl_e;
    logic [5*LANES-1:0]     rs_e, rt_e, rd_e;
    logic [WIDTH*LANES-1:0] rfout1_e, rfout2_e, imm_e, upperimm_e;
    logic [FSEL*LANES-1:0]  forwarda_e, forwardb_e;
    logic [WIDTH*LANES-1:0] execout_m, result_w;
    logic                   stall_in;
    logic                   busy_e;
    logic [LANES-1:0]       valid_m, regwrite_m;
    logic [WIDTH*LANES-1:0] execout_q;
    logic [5*LANES-1:0]     writereg_q;

    always #5 clk = ~clk;

    exe_stage_nlane #(.LANES(2), .WIDTH(32), .MUL_LAT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_e    (valid_e),
        .ctrl_e     (ctrl_e),
        .rs_e       (rs_e),
        .rt_e       (rt_e),
        .rd_e       (rd_e),
        .rfout1_e   (rfout1_e),
        .rfout2_e   (rfout2_e),
        .imm_e      (imm_e),
        .upperimm_e (upperimm_e),
        .forwarda_e (forwarda_e),
        .forwardb_e (forwardb_e),
        .execout_m  (execout_m),
        .result_w   (result_w),
        .stall_in   (stall_in),
        .busy_e     (busy_e),
        .valid_m    (valid_m),
        .regwrite_m (regwrite_m),
        .execout_q  (execout_q),
        .writereg_q (writereg_q)
    );

    typedef struct packed {
        logic [63:0] exec;
        logic [9:0]  wr;
        logic [1:0]  v;
        logic [1:0]  rw;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_e = '0; ctrl_e = '0; rs_e = '0; rt_e = '0; rd_e = '0;
        rfout1_e = '0; rfout2_e = '0; imm_e = '0; upperimm_e = '0;
        forwarda_e = '0; forwardb_e = '0; execout_m = '0; result_w = '0;
    endtask

    task automatic set_lane(input int k, input logic [7:0] c, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [31:0] uimm,
                            input logic [2:0] fa, input logic [2:0] fb);
        valid_e[k]             = 1'b1;
        ctrl_e[k*8 +: 8]       = c;
        rs_e[k*5 +: 5]         = 5'd1;
        rt_e[k*5 +: 5]         = rt;
        rd_e[k*5 +: 5]         = rd;
        rfout1_e[k*32 +: 32]   = a;
        rfout2_e[k*32 +: 32]   = b;
        imm_e[k*32 +: 32]      = imm;
        upperimm_e[k*32 +: 32] = uimm;
        forwarda_e[k*3 +: 3]   = fa;
        forwardb_e[k*3 +: 3]   = fb;
    endtask

    task automatic push_exp(input logic [63:0] ex, input logic [9:0] wr, input logic [1:0] v,
                            input logic [1:0] rw);
        exp_t e;
        e.exec = ex; e.wr = wr; e.v = v; e.rw = rw;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, " sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, " valid_m"}, 64'(valid_m), 64'(e.v));
        chk({tag, " regwrite_m"}, 64'(regwrite_m), 64'(e.rw));
        for (int k = 0; k < 2; k++) begin
            if (e.v[k]) begin
                chk($sformatf("%s execout%0d", tag, k), 64'(execout_q[k*32 +: 32]),
                    64'(e.exec[k*32 +: 32]));
                chk($sformatf("%s writereg%0d", tag, k), 64'(writereg_q[k*5 +: 5]),
                    64'(e.wr[k*5 +: 5]));
            end
        end
    endtask

    initial begin
        clear_inputs();
        stall_in = 1'b0;
        reset    = 1'b1;
        #12;
        chk("rst valid_m", 64'(valid_m), 64'd0);
        chk("rst regwrite_m", 64'(regwrite_m), 64'd0);
        chk("rst execout_q", execout_q, 64'd0);
        chk("rst writereg_q", 64'(writereg_q), 64'd0);
        chk("rst busy_e", 64'(busy_e), 64'd0);
        step();
        reset = 1'b0;

        // Two ADDs.
        set_lane(0, 8'hC2, 5'd2, 5'd5, 32'd0, 32'd10, 32'd0, 32'd0, 3'd0, 3'd0);
        set_lane(1, 8'hC2, 5'd3, 5'd25, 32'd20, 32'd30, 32'd0, 32'd0, 3'd0, 3'd0);
        push_exp({32'd50, 32'd10}, {5'd25, 5'd5}, 2'b11, 2'b11);
        #1 chk("add busy_e", 64'(busy_e), 64'd0);
        step();
        check_out("add");

        // Forwarding from M/W and the out-of-range fallback code.
        clear_inputs();
        execout_m = {32'd50, 32'd3};
        result_w  = {32'd100, 32'd7};
        set_lane(0, 8'hC2, 5'd2, 5'd5, 32'd999, 32'd888, 32'd0, 32'd0, 3'd2, 3'd3);
        set_lane(1, 8'hC2, 5'd3, 5'd25, 32'd11, 32'd444, 32'd0, 32'd0, 3'd7, 3'd4);
        push_exp({32'd111, 32'd57}, {5'd25, 5'd5}, 2'b11, 2'b11);
        step();
        check_out("fwd");

        // SLT / SLTU.
        clear_inputs();
        set_lane(0, 8'h87, 5'd7, 5'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 3'd0, 3'd0);
        set_lane(1, 8'h85, 5'd8, 5'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 3'd0, 3'd0);
        push_exp({32'd0, 32'd1}, {5'd8, 5'd7}, 2'b11, 2'b11);
        step();
        check_out("slt");

        // SRA by immediate, upper immediate.
        clear_inputs();
        set_lane(0, 8'hAB, 5'd9, 5'd1, 32'h8000_0000, 32'h55, 32'd4, 32'd0, 3'd0, 3'd0);
        set_lane(1, 8'h90, 5'd10, 5'd1, 32'd1, 32'd2, 32'd0, 32'h1234_0000, 3'd0, 3'd0);
        push_exp({32'h1234_0000, 32'hF800_0000}, {5'd10, 5'd9}, 2'b11, 2'b11);
        step();
        check_out("sra_upper");

        // XOR without regwrite; lane1 invalid despite regwrite in its ctrl.
        clear_inputs();
        set_lane(0, 8'h08, 5'd11, 5'd12, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 3'd0, 3'd0);
        set_lane(1, 8'hC2, 5'd3, 5'd4, 32'd1, 32'd1, 32'd0, 32'd0, 3'd0, 3'd0);
        valid_e[1] = 1'b0;
        push_exp({32'd0, 32'h0000_FF00}, {5'd0, 5'd11}, 2'b01, 2'b00);
        step();
        check_out("xor_inv");

        // Stall in idle: outputs hold the previous result, then the bundle issues.
        clear_inputs();
        set_lane(0, 8'hC2, 5'd2, 5'd13, 32'd3, 32'd4, 32'd0, 32'd0, 3'd0, 3'd0);
        set_lane(1, 8'hC2, 5'd3, 5'd14, 32'd1, 32'd1, 32'd0, 32'd0, 3'd0, 3'd0);
        stall_in = 1'b1;
        push_exp({32'd0, 32'h0000_FF00}, {5'd0, 5'd11}, 2'b01, 2'b00);
        #1 chk("idle stall busy_e", 64'(busy_e), 64'd1);
        step();
        check_out("idle_stall_hold");
        stall_in = 1'b0;
        push_exp({32'd2, 32'd7}, {5'd14, 5'd13}, 2'b11, 2'b11);
        #1 chk("post stall busy_e", 64'(busy_e), 64'd0);
        step();
        check_out("post_stall");

        // MUL bundle; forward sources change after issue and must be ignored.
        clear_inputs();
        execout_m = {32'd0, 32'd1};
        result_w  = {32'd1, 32'd0};
        set_lane(0, 8'hC4, 5'd2, 5'd9, 32'd7, 32'd6, 32'd0, 32'd0, 3'd0, 3'd0);
        set_lane(1, 8'hC2, 5'd3, 5'd10, 32'd77, 32'd88, 32'd0, 32'd0, 3'd1, 3'd4);
        push_exp({32'd2, 32'd42}, {5'd10, 5'd9}, 2'b11, 2'b11);
        #1 chk("mul busy T", 64'(busy_e), 64'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            execout_m = {$urandom(), $urandom()};
            result_w  = {$urandom(), $urandom()};
            #1;
            chk($sformatf("mul busy T+%0d", i), 64'(busy_e), 64'(i <= 2));
            chk($sformatf("mul bubble T+%0d", i), 64'(valid_m), 64'd0);
        end
        step();
        check_out("mul");
        clear_inputs();
        #1 chk("mul after busy_e", 64'(busy_e), 64'd0);
        step();
        chk("mul no reissue valid_m", 64'(valid_m), 64'd0);

        // MUL with a two-cycle stall mid-operation; result wraps modulo 2^32.
        set_lane(0, 8'hC4, 5'd2, 5'd15, 32'h0001_0000, 32'h0001_0001, 32'd0, 32'd0, 3'd0, 3'd0);
        set_lane(1, 8'hC6, 5'd3, 5'd16, 32'd5, 32'd7, 32'd0, 32'd0, 3'd0, 3'd0);
        push_exp({32'hFFFF_FFFE, 32'h0001_0000}, {5'd16, 5'd15}, 2'b11, 2'b11);
        #1 chk("mstall busy T", 64'(busy_e), 64'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            stall_in = (i <= 2);
            #1;
            chk($sformatf("mstall busy T+%0d", i), 64'(busy_e), 64'(i <= 4));
            chk($sformatf("mstall bubble T+%0d", i), 64'(valid_m), 64'd0);
        end
        step();
        check_out("mul_stall");
        clear_inputs();

        // Reset at T+2 of a multiply: immediate clear, no result afterwards.
        set_lane(0, 8'hC4, 5'd2, 5'd17, 32'd3, 32'd5, 32'd0, 32'd0, 3'd0, 3'd0);
        set_lane(1, 8'hC2, 5'd3, 5'd18, 32'd1, 32'd1, 32'd0, 32'd0, 3'd0, 3'd0);
        #1 chk("rmul busy T", 64'(busy_e), 64'd1);
        step();
        step();
        #1 reset = 1'b1;
        #1;
        chk("rmul valid_m", 64'(valid_m), 64'd0);
        chk("rmul regwrite_m", 64'(regwrite_m), 64'd0);
        chk("rmul execout_q", execout_q, 64'd0);
        chk("rmul writereg_q", 64'(writereg_q), 64'd0);
        chk("rmul busy_e", 64'(busy_e), 64'd0);
        step();
        reset = 1'b0;
        clear_inputs();
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("rmul no result +%0d", i), 64'(valid_m), 64'd0);
        end
        set_lane(0, 8'hC2, 5'd2, 5'd19, 32'd4, 32'd5, 32'd0, 32'd0, 3'd0, 3'd0);
        push_exp({32'd0, 32'd9}, {5'd0, 5'd19}, 2'b01, 2'b01);
        #1 chk("rmul idle busy_e", 64'(busy_e), 64'd0);
        step();
        check_out("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
